scr1_wfi_ctrl: RTL

SCR1_WFI_CTRL -- requirements
Module: scr1_wfi_ctrl

---
 rtl/scr1_wfi_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/scr1_wfi_ctrl.sv
// rtl/scr1_wfi_ctrl.sv - WFI sleep/wake sequencer between pipeline and clock control
//
// Sequences a retired WFI instruction into a pipe clock-disable request and
// back out again when an interrupt or debug halt request arrives.
// Runs on the always-on core clock; never on the gated pipe clock.
//
// Ports:
//   clk                     always-on core clock
//   rst_n                   asynchronous active-low reset
//   pipe2wfi_start_i        one-cycle pulse, WFI retired
//   pipe2wfi_idle_i         pipe has no outstanding fetch/LSU transactions
//   irq_pending_i           enabled interrupt pending (level)
//   dbg_halt_req_i          debug halt request (level)
//   clkctl2wfi_clk_en_i     clock-enable flag fed back from clock control
//   wfi2clkctl_sleep_req_o  clock-disable request
//   wfi2clkctl_wake_req_o   clock-enable request
//   wfi2pipe_stall_o        hold instruction fetch/issue
//   wfi2pipe_halted_o       core is in WFI sleep
//   wfi2pipe_exit_o         one-cycle pulse, WFI exited

module scr1_wfi_ctrl #(
    parameter int unsigned SCR1_WFI_SLEEP_DLY = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pipe2wfi_start_i,
    input  logic pipe2wfi_idle_i,
    input  logic irq_pending_i,
    input  logic dbg_halt_req_i,
    input  logic clkctl2wfi_clk_en_i,
    output logic wfi2clkctl_sleep_req_o,
    output logic wfi2clkctl_wake_req_o,
    output logic wfi2pipe_stall_o,
    output logic wfi2pipe_halted_o,
    output logic wfi2pipe_exit_o
);

    typedef enum logic [1:0] {
        WFI_RUN   = 2'd0,
        WFI_DRAIN = 2'd1,
        WFI_SLEEP = 2'd2,
        WFI_WAKE  = 2'd3
    } wfi_state_e;

    localparam logic [3:0] CNT_LAST = 4'(SCR1_WFI_SLEEP_DLY - 1);

    wfi_state_e state;
    wfi_state_e state_next;
    logic [3:0] idle_cnt;
    logic [3:0] idle_cnt_next;
    logic       wake_ev;

    assign wake_ev = irq_pending_i | dbg_halt_req_i;

    always_comb begin
        state_next    = state;
        idle_cnt_next = idle_cnt;
        case (state)
            WFI_RUN: begin
                // A WFI retired with a wake event already pending is a NOP.
                if (pipe2wfi_start_i && !wake_ev) begin
                    state_next    = WFI_DRAIN;
                    idle_cnt_next = 4'd0;
                end
            end
            WFI_DRAIN: begin
                if (wake_ev) begin
                    state_next = WFI_WAKE;
                end else if (pipe2wfi_idle_i && (idle_cnt == CNT_LAST)) begin
                    state_next = WFI_SLEEP;
                end else if (pipe2wfi_idle_i) begin
                    idle_cnt_next = idle_cnt + 4'd1;
                end else begin
                    // Idle must be seen on consecutive cycles.
                    idle_cnt_next = 4'd0;
                end
            end
            WFI_SLEEP: begin
                if (wake_ev) begin
                    state_next = WFI_WAKE;
                end
            end
            WFI_WAKE: begin
                // Once committed, wake completes even if wake_ev drops.
                if (clkctl2wfi_clk_en_i) begin
                    state_next = WFI_RUN;
                end
            end
            default: begin
                state_next = WFI_RUN;
            end
        endcase
    end

    // Outputs are registered decodes of the next state so they line up
    // cycle-for-cycle with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                  <= WFI_RUN;
            idle_cnt               <= 4'd0;
            wfi2clkctl_sleep_req_o <= 1'b0;
            wfi2clkctl_wake_req_o  <= 1'b0;
            wfi2pipe_stall_o       <= 1'b0;
            wfi2pipe_halted_o      <= 1'b0;
            wfi2pipe_exit_o        <= 1'b0;
        end else begin
            state                  <= state_next;
            idle_cnt               <= idle_cnt_next;
            wfi2clkctl_sleep_req_o <= (state_next == WFI_SLEEP);
            wfi2clkctl_wake_req_o  <= (state_next == WFI_WAKE);
            wfi2pipe_stall_o       <= (state_next != WFI_RUN);
            wfi2pipe_halted_o      <= (state_next == WFI_SLEEP);
            wfi2pipe_exit_o        <= (state == WFI_WAKE) && (state_next == WFI_RUN);
        end
    end

endmodule
